// File: rtl/car_game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : car_game_pkg
//  Description : Shared constants and types for the car game blocks:
//                playfield size, car size, lane geometry, spawn timing,
//                the lane-LFSR step function and the obstacle FSM encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package car_game_pkg;

    localparam int          SCREEN_W   = 640;
    localparam int          SCREEN_H   = 480;
    localparam int          CAR_W      = 32;
    localparam int          CAR_H      = 64;

    localparam int          LANE_BASE  = 160;
    localparam int          LANE_PITCH = 80;
    localparam int          NUM_LANES  = 4;

    localparam int          SPAWN_GAP  = 30;
    localparam logic [7:0]  LFSR_SEED  = 8'hA5;

    // Obstacle car state machine, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_SPAWN = 2'd1,
        ST_ACTIVE     = 2'd2,
        ST_CRASHED    = 2'd3
    } state_t;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4 (maximal length, 255 states).
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dodge_car_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dodge_car_ctrl_if
//  Description : Game-side bundle of the obstacle car controller.
//                Inputs : game_start, frame_tick, speed[3:0],
//                         player_x[9:0], player_y[9:0]
//                Outputs: car_x[9:0], car_y[9:0], enable (to renderer),
//                         dodged, crash (pulses), crashed (level)
//                slave  = the controller, master = game/score logic.
//  Revision    : 1.0  initial release
// ============================================================================
interface dodge_car_ctrl_if;

    logic       game_start;
    logic       frame_tick;
    logic [3:0] speed;
    logic [9:0] player_x;
    logic [9:0] player_y;

    logic [9:0] car_x;
    logic [9:0] car_y;
    logic       enable;
    logic       dodged;
    logic       crash;
    logic       crashed;

    modport slave (
        input  game_start, frame_tick, speed, player_x, player_y,
        output car_x, car_y, enable, dodged, crash, crashed
    );

    modport master (
        output game_start, frame_tick, speed, player_x, player_y,
        input  car_x, car_y, enable, dodged, crash, crashed
    );

endinterface
`default_nettype wire

// File: rtl/dodge_car_ctrl_bbox_overlap.sv
`default_nettype none
// ============================================================================
//  Module      : bbox_overlap
//  Description : Combinational overlap test of two CAR_W x CAR_H boxes given
//                by their top-left corners. All sums are carried at 11 bits
//                so boxes near the right/bottom limit never wrap.
//                Ports: a_x, a_y, b_x, b_y [9:0] in; overlap out.
//  Revision    : 1.0  initial release
// ============================================================================
module bbox_overlap #(
    parameter int CAR_W = 32,
    parameter int CAR_H = 64
) (
    input  wire logic [9:0] a_x,
    input  wire logic [9:0] a_y,
    input  wire logic [9:0] b_x,
    input  wire logic [9:0] b_y,
    output logic            overlap
);

    logic [10:0] w_ax;
    logic [10:0] w_ay;
    logic [10:0] w_bx;
    logic [10:0] w_by;

    assign w_ax = {1'b0, a_x};
    assign w_ay = {1'b0, a_y};
    assign w_bx = {1'b0, b_x};
    assign w_by = {1'b0, b_y};

    assign overlap = (w_ax < (w_bx + 11'(CAR_W))) &&
                     (w_bx < (w_ax + 11'(CAR_W))) &&
                     (w_ay < (w_by + 11'(CAR_H))) &&
                     (w_by < (w_ay + 11'(CAR_H)));

endmodule
`default_nettype wire

// File: rtl/dodge_car_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dodge_car_ctrl
//  Description : Position/enable generator for the obstacle car renderer.
//                Once per frame moves the obstacle down the playfield,
//                respawns it in a pseudo-random lane after a gap, and
//                reports crashes against the player car and clean dodges.
//                Ports: clk, reset_n (async, active low),
//                       bus (dodge_car_ctrl_if.slave).
//  Revision    : 1.0  initial release
// ============================================================================
module dodge_car_ctrl
    import car_game_pkg::*;
#(
    parameter int         SCREEN_H   = car_game_pkg::SCREEN_H,
    parameter int         CAR_W      = car_game_pkg::CAR_W,
    parameter int         CAR_H      = car_game_pkg::CAR_H,
    parameter int         LANE_BASE  = car_game_pkg::LANE_BASE,
    parameter int         LANE_PITCH = car_game_pkg::LANE_PITCH,
    parameter int         SPAWN_GAP  = car_game_pkg::SPAWN_GAP,
    parameter logic [7:0] LFSR_SEED  = car_game_pkg::LFSR_SEED
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    dodge_car_ctrl_if.slave    bus
);

    localparam int GAP_W = $clog2(SPAWN_GAP + 1);

    // Registered state
    state_t           r_state;
    logic [9:0]       r_car_x;
    logic [9:0]       r_car_y;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [7:0]       r_lfsr;
    logic             r_hit;
    logic             r_dodged;
    logic             r_crash;

    // Next-state values
    state_t           w_state_nxt;
    logic [9:0]       w_car_x_nxt;
    logic [9:0]       w_car_y_nxt;
    logic [GAP_W-1:0] w_gap_nxt;
    logic             w_dodged_nxt;
    logic             w_crash_nxt;

    logic             w_overlap;
    logic [10:0]      w_sum;
    logic [9:0]       w_lane_x;

    bbox_overlap #(
        .CAR_W (CAR_W),
        .CAR_H (CAR_H)
    ) u_bbox (
        .a_x     (r_car_x),
        .a_y     (r_car_y),
        .b_x     (bus.player_x),
        .b_y     (bus.player_y),
        .overlap (w_overlap)
    );

    assign w_sum    = {1'b0, r_car_y} + {7'd0, bus.speed};
    assign w_lane_x = 10'(LANE_BASE) + (10'(r_lfsr[1:0]) * 10'(LANE_PITCH));

    always_comb begin
        w_state_nxt  = r_state;
        w_car_x_nxt  = r_car_x;
        w_car_y_nxt  = r_car_y;
        w_gap_nxt    = r_gap_cnt;
        w_dodged_nxt = 1'b0;
        w_crash_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.game_start) begin
                    w_state_nxt = ST_WAIT_SPAWN;
                    w_gap_nxt   = GAP_W'(SPAWN_GAP);
                end
            end

            ST_WAIT_SPAWN: begin
                if (bus.game_start) begin
                    w_gap_nxt = GAP_W'(SPAWN_GAP);
                end else if (bus.frame_tick) begin
                    if (r_gap_cnt == '0) begin
                        w_car_x_nxt = w_lane_x;
                        w_car_y_nxt = 10'd0;
                        w_state_nxt = ST_ACTIVE;
                    end else begin
                        w_gap_nxt = r_gap_cnt - GAP_W'(1);
                    end
                end
            end

            ST_ACTIVE: begin
                // Restart beats crash, crash beats movement.
                if (bus.game_start) begin
                    w_state_nxt = ST_WAIT_SPAWN;
                    w_gap_nxt   = GAP_W'(SPAWN_GAP);
                end else if (r_hit) begin
                    w_crash_nxt = 1'b1;
                    w_state_nxt = ST_CRASHED;
                end else if (bus.frame_tick) begin
                    if (w_sum >= 11'(SCREEN_H)) begin
                        w_dodged_nxt = 1'b1;
                        w_gap_nxt    = GAP_W'(SPAWN_GAP);
                        w_state_nxt  = ST_WAIT_SPAWN;
                    end else begin
                        w_car_y_nxt = w_sum[9:0];
                    end
                end
            end

            ST_CRASHED: begin
                // Position is frozen so the wreck stays on screen.
                if (bus.game_start) begin
                    w_state_nxt = ST_WAIT_SPAWN;
                    w_gap_nxt   = GAP_W'(SPAWN_GAP);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_car_x   <= 10'(LANE_BASE);
            r_car_y   <= 10'd0;
            r_gap_cnt <= '0;
            r_lfsr    <= LFSR_SEED;
            r_hit     <= 1'b0;
            r_dodged  <= 1'b0;
            r_crash   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_car_x   <= w_car_x_nxt;
            r_car_y   <= w_car_y_nxt;
            r_gap_cnt <= w_gap_nxt;
            // Free-running so the lane depends on when play starts.
            r_lfsr    <= lfsr_next(r_lfsr);
            r_hit     <= w_overlap;
            r_dodged  <= w_dodged_nxt;
            r_crash   <= w_crash_nxt;
        end
    end

    // enable derives straight from the state register, so an asserted
    // reset hides the car in the same cycle.
    assign bus.car_x   = r_car_x;
    assign bus.car_y   = r_car_y;
    assign bus.enable  = (r_state == ST_ACTIVE) || (r_state == ST_CRASHED);
    assign bus.dodged  = r_dodged;
    assign bus.crash   = r_crash;
    assign bus.crashed = (r_state == ST_CRASHED);

endmodule
`default_nettype wire
